// File: rtl/audio_source_mixer_if.sv
// Bus between the sample sources/codec side and audio_source_mixer.
// master drives source selection, frame strobes and samples; slave is the mixer.
interface audio_source_mixer_if #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SEL_W    = 1
);
  logic [SEL_W-1:0]            sel;
  logic                        new_frame;
  logic [NUM_SRC*SAMPLE_W-1:0] src_sample;
  logic [NUM_SRC-1:0]          src_new_sample;
  logic [NUM_SRC-1:0]          src_reset;
  logic [SAMPLE_W-1:0]         sample_out;
  logic                        new_sample_out;
  logic                        fade_busy;

  modport master (
    output sel, new_frame, src_sample, src_new_sample,
    input  src_reset, sample_out, new_sample_out, fade_busy
  );

  modport slave (
    input  sel, new_frame, src_sample, src_new_sample,
    output src_reset, sample_out, new_sample_out, fade_busy
  );
endinterface

// File: rtl/audio_source_mixer.sv
// N-source audio selector with click-free crossfade (fade-out, switch, fade-in).
// Unselected sources are held in reset; a registered sample plus a one-cycle
// new-sample strobe feed the codec and the wave display.
// Optional build macro MIXER_SRC_STROBE_EN: output samples are timed by the
// active source's own new-sample strobe instead of new_frame.
module audio_source_mixer #(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned SEL_W     = 1,
  parameter int unsigned FADE_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  audio_source_mixer_if.slave   bus
);
  localparam int unsigned GAIN_W = FADE_LOG2 + 1;
  localparam int unsigned PROD_W = SAMPLE_W + FADE_LOG2 + 2;
  localparam logic [GAIN_W-1:0]  UNITY    = GAIN_W'(2 ** FADE_LOG2);
  localparam logic [NUM_SRC-1:0] RST_INIT = ~NUM_SRC'(1);

  typedef enum logic [1:0] {
    STEADY,
    FADE_OUT,
    SWITCH,
    FADE_IN
  } state_t;

  state_t                      state, state_next;
  logic [SEL_W-1:0]            active, active_next;
  logic [SEL_W-1:0]            target, target_next;
  logic [GAIN_W-1:0]           gain, gain_next;
  logic [NUM_SRC-1:0]          src_reset_q, src_reset_next;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_next;
  logic                        new_sample_q, new_sample_next;
  logic                        fade_busy_q;
  logic signed [SAMPLE_W-1:0]  cur_sample;
  logic signed [PROD_W-1:0]    prod;
  logic                        upd;

  // Currently audible source scaled by the pre-update gain
  assign cur_sample = $signed(bus.src_sample[32'(active)*SAMPLE_W +: SAMPLE_W]);
  assign prod       = PROD_W'(cur_sample) * PROD_W'($signed({1'b0, gain}));

`ifdef MIXER_SRC_STROBE_EN
  // Output sample timed by the active source's own strobe
  assign upd = bus.src_new_sample[active];
`else
  // Output sample timed by the codec frame; source strobes are not needed
  assign upd = bus.new_frame;
  logic unused_strobe;
  assign unused_strobe = |bus.src_new_sample;
`endif

  // Next-state, gain stepping and output sample computation
  always_comb begin
    state_next      = state;
    active_next     = active;
    gain_next       = gain;
    src_reset_next  = src_reset_q;
    target_next     = (32'(bus.sel) < NUM_SRC) ? bus.sel : target;
    sample_next     = upd ? SAMPLE_W'(prod >>> FADE_LOG2) : sample_q;
    new_sample_next = upd;

    case (state)
      STEADY: begin
        if (target != active) state_next = FADE_OUT;
      end
      FADE_OUT: begin
        if (target == active)   state_next = FADE_IN;
        else if (gain == '0)    state_next = SWITCH;
        else if (bus.new_frame) gain_next  = gain - GAIN_W'(1);
      end
      SWITCH: begin
        // Old source enters reset and new one leaves it on the same edge
        active_next    = target;
        src_reset_next = ~(NUM_SRC'(1) << target);
        state_next     = FADE_IN;
      end
      FADE_IN: begin
        if (target != active)   state_next = FADE_OUT;
        else if (gain == UNITY) state_next = STEADY;
        else if (bus.new_frame) gain_next  = gain + GAIN_W'(1);
      end
      default: state_next = STEADY;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= STEADY;
      active       <= '0;
      target       <= '0;
      gain         <= UNITY;
      src_reset_q  <= RST_INIT;
      sample_q     <= '0;
      new_sample_q <= 1'b0;
      fade_busy_q  <= 1'b0;
    end else begin
      state        <= state_next;
      active       <= active_next;
      target       <= target_next;
      gain         <= gain_next;
      src_reset_q  <= src_reset_next;
      sample_q     <= sample_next;
      new_sample_q <= new_sample_next;
      fade_busy_q  <= (state_next != STEADY);
    end
  end

  assign bus.src_reset      = src_reset_q;
  assign bus.sample_out     = sample_q;
  assign bus.new_sample_out = new_sample_q;
  assign bus.fade_busy      = fade_busy_q;
endmodule
